pipelined_tree_multiplier: RTL and testbench

PIPELINED_TREE_MULTIPLIER -- requirements
Module: pipelined_tree_multiplier

---
 rtl/pipelined_tree_multiplier.sv | 195 +++++++++++++++++++
 tb/tb_pipelined_tree_multiplier.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_tree_multiplier.sv
// Pipelined tree multiplier with optional accumulate.
//
// Operands are expanded into partial products, reduced by a carry-save (3:2) tree to a
// sum/carry pair, carried through the pipeline, and resolved by a final carry-propagate
// add in the output register, where the optional accumulate also happens. The whole
// pipeline advances together; a stall freezes every stage.
//
// Timing:
//   - A beat accepted on an edge is visible on out STAGES cycles later when nothing stalls.
//   - A result is consumed on an edge with out_valid && out_ready && enable.
//
// Parameters:
//   WIDTH   operand width (4..64)
//   STAGES  register stages from operand capture to output (1..6)
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   enable              global advance; 0 freezes all pipeline state
//   in_valid/in_ready   operand handshake
//   in1, in2            operands
//   is_signed           1: two's-complement product, 0: unsigned product
//   acc_en, acc_clear   accumulate, restart accumulator (clear ignored without acc_en)
//   out_valid/out_ready result handshake
//   out                 2*WIDTH product or accumulated sum
//   acc_ovf             sticky accumulator overflow
module pipelined_tree_multiplier #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               is_signed,
  input  logic               acc_en,
  input  logic               acc_clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               acc_ovf
);

  localparam int P  = 2 * WIDTH;
  // One row per multiplier bit plus a +1 row completing the negated sign row.
  localparam int NR = WIDTH + 1;

  typedef struct packed {
    logic         valid;
    logic         sgn;
    logic         acc;
    logic         clr;
    logic [P-1:0] sum;
    logic [P-1:0] car;
  } beat_t;

  // Wallace-style reduction: each level compresses groups of three rows into two.
  function automatic logic [2*P-1:0] reduce_tree(input logic [NR-1:0][P-1:0] rows);
    logic [NR+1:0][P-1:0] r;
    logic [NR+1:0][P-1:0] t;
    int n;
    int m;
    r = '0;
    r[NR-1:0] = rows;
    t = '0;
    n = NR;
    for (int lvl = 0; lvl < NR; lvl++) begin
      if (n > 2) begin
        m = 0;
        t = '0;
        for (int j = 0; j < NR; j += 3) begin
          if (j + 2 < n) begin
            t[m]   = r[j] ^ r[j+1] ^ r[j+2];
            t[m+1] = ((r[j] & r[j+1]) | (r[j] & r[j+2]) | (r[j+1] & r[j+2])) << 1;
            m = m + 2;
          end else if (j < n) begin
            t[m] = r[j];
            m = m + 1;
            if (j + 1 < n) begin
              t[m] = r[j+1];
              m = m + 1;
            end
          end
        end
        r = t;
        n = m;
      end
    end
    return {r[1], r[0]};
  endfunction

  logic         adv;
  logic         out_valid_q;
  logic [P-1:0] out_q;
  logic [P-1:0] acc_q;
  logic         acc_ovf_q;

  assign adv       = enable && !(out_valid_q && !out_ready);
  assign in_ready  = adv && !reset;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign acc_ovf   = acc_ovf_q;

  // Partial products and tree reduction of the incoming beat.
  logic [P-1:0]         a_ext;
  logic                 neg_row;
  logic [NR-1:0][P-1:0] pp;
  beat_t                head;

  always_comb begin
    a_ext   = is_signed ? {{WIDTH{in1[WIDTH-1]}}, in1} : {{WIDTH{1'b0}}, in1};
    // In signed mode the multiplier MSB weighs -2^(WIDTH-1): add ~row + 1.
    neg_row = is_signed && in2[WIDTH-1];
    pp      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pp[i] = in2[i] ? (a_ext << i) : '0;
    end
    if (neg_row) begin
      pp[WIDTH-1] = ~(a_ext << (WIDTH - 1));
    end
    pp[WIDTH] = {{(P-1){1'b0}}, neg_row};

    head            = '0;
    head.valid      = in_valid && in_ready;
    head.sgn        = is_signed;
    head.acc        = acc_en;
    head.clr        = acc_en && acc_clear;
    {head.car, head.sum} = reduce_tree(pp);
  end

  beat_t tail;

  if (STAGES == 1) begin : g_direct
    assign tail = head;
  end else begin : g_pipe
    beat_t pipe_q [STAGES-1];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < STAGES - 1; i++) begin
          pipe_q[i].valid <= 1'b0;
        end
      end else if (adv) begin
        pipe_q[0] <= head;
        for (int i = 1; i < STAGES - 1; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign tail = pipe_q[STAGES-2];
  end

  // Final carry-propagate add and accumulate.
  logic [P-1:0] prod;
  logic [P:0]   acc_wide;
  logic         step_ovf;

  always_comb begin
    prod     = tail.sum + tail.car;
    acc_wide = {1'b0, acc_q} + {1'b0, prod};
    if (tail.sgn) begin
      step_ovf = (acc_q[P-1] == prod[P-1]) && (acc_wide[P-1] != acc_q[P-1]);
    end else begin
      step_ovf = acc_wide[P];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      acc_q       <= '0;
      acc_ovf_q   <= 1'b0;
    end else if (adv) begin
      out_valid_q <= tail.valid;
      if (tail.valid) begin
        if (tail.clr) begin
          out_q     <= prod;
          acc_q     <= prod;
          acc_ovf_q <= 1'b0;
        end else if (tail.acc) begin
          out_q     <= acc_wide[P-1:0];
          acc_q     <= acc_wide[P-1:0];
          acc_ovf_q <= acc_ovf_q | step_ovf;
        end else begin
          out_q <= prod;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_tree_multiplier.sv
module tb_pipelined_tree_multiplier;

  localparam int W  = 32;
  localparam int ST = 3;

  logic           clk = 1'b0;
  logic           reset, enable, in_valid, in_ready, is_signed, acc_en, acc_clear;
  logic           out_valid, out_ready, acc_ovf;
  logic [W-1:0]   in1, in2;
  logic [2*W-1:0] out;

  always #5 clk = ~clk;

  pipelined_tree_multiplier #(.WIDTH(W), .STAGES(ST)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .is_signed (is_signed),
    .acc_en    (acc_en),
    .acc_clear (acc_clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .acc_ovf   (acc_ovf)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int stall_cnt = 0;

  typedef struct {
    logic [63:0] val;
    logic        ovf;
    int          cyc;
    int          stalls;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [63:0] m_acc = '0;
  logic        m_ovf = 1'b0;
  logic        prev_hold = 1'b0;
  logic [63:0] prev_out;
  logic        mon_adv;
  logic [63:0] p, ev;
  logic [64:0] uw;
  logic signed [64:0] sw;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Exact product from plain integer arithmetic.
  function automatic logic [63:0] mprod(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    longint sa, sb;
    logic [63:0] ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Compare process: model predicted at acceptance, checked at consumption.
  always @(posedge clk) begin
    if (reset) begin
      check("in_ready_in_reset", {63'b0, in_ready}, 64'd0);
      q.delete();
      m_acc = '0;
      m_ovf = 1'b0;
      prev_hold = 1'b0;
    end else begin
      mon_adv = enable && !(out_valid && !out_ready);
      check("in_ready", {63'b0, in_ready}, {63'b0, mon_adv});
      if (prev_hold) begin
        check("hold_valid", {63'b0, out_valid}, 64'd1);
        check("hold_out", out, prev_out);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_valid", {63'b0, out_valid}, 64'd0);
        end else if (mon_adv) begin
          e = q.pop_front();
          check("out", out, e.val);
          check("acc_ovf", {63'b0, acc_ovf}, {63'b0, e.ovf});
          check("latency", 64'(cyc - e.cyc), 64'(ST + stall_cnt - e.stalls));
        end
      end
      if (in_valid && in_ready) begin
        p = mprod(in1, in2, is_signed);
        if (acc_en && acc_clear) begin
          m_acc = p;
          m_ovf = 1'b0;
          ev = p;
        end else if (acc_en) begin
          uw = {1'b0, m_acc} + {1'b0, p};
          sw = $signed({m_acc[63], m_acc}) + $signed({p[63], p});
          m_ovf = m_ovf | (is_signed ? (sw[64] != sw[63]) : uw[64]);
          m_acc = uw[63:0];
          ev = uw[63:0];
        end else begin
          ev = p;
        end
        q.push_back('{ev, m_ovf, cyc, stall_cnt});
      end
      prev_hold = out_valid && !mon_adv;
      prev_out = out;
      if (!mon_adv) stall_cnt++;
    end
    cyc++;
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic ae, input logic ac, output int waits);
    logic got;
    in1 = a; in2 = b; is_signed = s; acc_en = ae; acc_clear = ac; in_valid = 1'b1;
    waits = 0;
    do begin
      @(posedge clk);
      got = in_ready;
      waits++;
    end while (!got && waits < 100);
    if (!got) check("send_timeout", 64'd0, 64'd1);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    enable = 1'b1;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic ovf_seq();
    int w;
    send(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1, w);
    send(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, w);
    send(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, w);
    drain();
  endtask

  logic [31:0] sa [10] = '{32'd4, 32'hFFFFFFFC, 32'd0, 32'd1, 32'd3, 32'd2, 32'd5, 32'd0,
                           32'd7, 32'hFFFFFFFB};
  logic [31:0] sb [10] = '{32'd10, 32'hFFFFFFF6, 32'd3, 32'd3, 32'd7, 32'hFFFFFFFE, 32'd7,
                           32'd0, 32'd7, 32'd5};

  initial begin
    int w;
    reset = 1'b1; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in1 = '0; in2 = '0; is_signed = 1'b0; acc_en = 1'b0; acc_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {63'b0, out_valid}, 64'd0);
    check("reset_out", out, 64'd0);
    check("reset_acc_ovf", {63'b0, acc_ovf}, 64'd0);
    reset = 1'b0;
    enable = 1'b1;

    // Literal anchors for the model.
    check("model_neg5x5", mprod(32'hFFFFFFFB, 32'd5, 1'b1), 64'hFFFFFFFF_FFFFFFE7);
    check("model_umax_x2", mprod(32'hFFFFFFFF, 32'd2, 1'b0), 64'h00000001_FFFFFFFE);
    check("model_smin_sq", mprod(32'h80000000, 32'h80000000, 1'b1), 64'h40000000_00000000);
    check("model_neg1_sq", mprod(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1), 64'd1);
    check("model_umax_sq", mprod(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0), 64'hFFFFFFFE_00000001);

    // Directed extremes; first beat after reset must go on the first edge.
    send(32'hFFFFFFFB, 32'd5, 1'b1, 1'b0, 1'b0, w);
    check("first_beat_accept_edges", 64'(w), 64'd1);
    send(32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, 1'b0, w);
    send(32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b0, w);
    drain();
    check("last_extreme_out", out, 64'h40000000_00000000);

    // Back-to-back stream.
    for (int i = 0; i < 10; i++) send(sa[i], sb[i], 1'b1, 1'b0, 1'b0, w);
    drain();
    check("stream_last_out", out, 64'hFFFFFFFF_FFFFFFE7);

    // Backpressure and enable freeze mid-stream.
    fork
      begin
        int wb;
        for (int i = 0; i < 12; i++) send(32'(i + 1), 32'(3 * i - 7), 1'b1, 1'b0, 1'b0, wb);
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 enable = 1'b1;
      end
    join
    drain();

    // Accumulate: 21, 56, 16.
    send(32'd3, 32'd7, 1'b1, 1'b1, 1'b1, w);
    send(32'd5, 32'd7, 1'b1, 1'b1, 1'b0, w);
    send(32'hFFFFFFFC, 32'd10, 1'b1, 1'b1, 1'b0, w);
    drain();
    check("acc_final_out", out, 64'd16);
    ovf_seq();
    check("ovf_set", {63'b0, acc_ovf}, 64'd1);
    send(32'd3, 32'd7, 1'b1, 1'b1, 1'b1, w);
    drain();
    check("ovf_cleared", {63'b0, acc_ovf}, 64'd0);
    check("clear_out", out, 64'd21);
    ovf_seq();
    check("ovf_set_again", {63'b0, acc_ovf}, 64'd1);

    // Reset with beats in flight.
    send(32'd2, 32'd3, 1'b0, 1'b0, 1'b0, w);
    send(32'd4, 32'd5, 1'b0, 1'b0, 1'b0, w);
    send(32'd6, 32'd9, 1'b0, 1'b0, 1'b0, w);
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    check("midreset_out_valid", {63'b0, out_valid}, 64'd0);
    check("midreset_out", out, 64'd0);
    check("midreset_acc_ovf", {63'b0, acc_ovf}, 64'd0);
    repeat (6) @(posedge clk);
    #1;
    check("midreset_no_emit", {63'b0, out_valid}, 64'd0);
    send(32'd6, 32'd7, 1'b0, 1'b0, 1'b0, w);
    drain();
    check("post_reset_out", out, 64'd42);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in1 = pick();
      in2 = pick();
      is_signed = 1'($urandom_range(0, 1));
      acc_en = ($urandom_range(0, 2) == 0);
      acc_clear = ($urandom_range(0, 3) == 0);
      enable = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
